// File: rtl/synth_audio_pkg.sv
// Shared framing definitions for the Pmod audio paths, so the ADC receiver and
// DAC output agree on SCLK rate, slot count and sample type.
package synth_audio_pkg;

    typedef logic signed [15:0] sample_t;

    typedef enum logic {
        ChLeft  = 1'b0,
        ChRight = 1'b1
    } chan_e;

    localparam int unsigned AUDIO_CLK_PER_SCLK = 16;
    localparam int unsigned AUDIO_SLOTS        = 32;
    localparam int unsigned AUDIO_MCLK_DIV     = 4;

    // Divider bit whose value is a square wave at clk / AUDIO_MCLK_DIV.
    localparam int unsigned AUDIO_MCLK_TAP = $clog2(AUDIO_MCLK_DIV) - 1;

endpackage

// File: rtl/i2s_clkgen.sv
// I2S master timing: divider and bit counters, registered MCLK/SCLK/LRCK and
// the per-bit capture and word-end strobes used by a deserialiser.
module i2s_clkgen
    import synth_audio_pkg::*;
#(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned CLK_PER_SCLK = AUDIO_CLK_PER_SCLK,
    parameter int unsigned SLOTS        = AUDIO_SLOTS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic mclk,
    output logic sclk,
    output logic lrck,
    output logic cap_bit,
    output logic left_end,
    output logic frame_end
);

    localparam int unsigned DIV_W = $clog2(CLK_PER_SCLK);
    localparam int unsigned BIT_W = $clog2(2 * SLOTS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_PER_SCLK - 1);
    localparam logic [DIV_W-1:0] SCLK_HI  = DIV_W'(CLK_PER_SCLK / 2);
    localparam logic [DIV_W-1:0] CAP_DIV  = DIV_W'(CLK_PER_SCLK / 2 + 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOTS - 1);
    localparam logic [BIT_W-1:0] SLOTS_B  = BIT_W'(SLOTS);
    localparam logic [BIT_W-1:0] LSB_SLOT = BIT_W'(WIDTH);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [BIT_W-1:0] slot;
    chan_e            chan;
    logic             cap_pt;
    logic             data_slot;
    logic             mclk_q, mclk_d;
    logic             sclk_q, sclk_d;
    logic             lrck_q, lrck_d;

    always_comb begin
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        if (!en) begin
            div_cnt_d = '0;
            bit_cnt_d = '0;
        end else if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
        end else begin
            div_cnt_d = div_cnt_q + 1'b1;
        end
    end

    always_comb begin
        chan      = (bit_cnt_q >= SLOTS_B) ? ChRight : ChLeft;
        slot      = (chan == ChRight) ? bit_cnt_q - SLOTS_B : bit_cnt_q;
        // Slot 0 is the I2S one-bit delay; slots past the LSB are padding.
        data_slot = (slot != '0) && (slot <= LSB_SLOT);
        cap_pt    = en && (div_cnt_q == CAP_DIV);
        cap_bit   = cap_pt && data_slot;
        left_end  = cap_pt && (slot == LSB_SLOT) && (chan == ChLeft);
        frame_end = cap_pt && (slot == LSB_SLOT) && (chan == ChRight);
    end

    always_comb begin
        mclk_d = en && div_cnt_q[AUDIO_MCLK_TAP];
        sclk_d = en && (div_cnt_q >= SCLK_HI);
        lrck_d = en && (chan == ChRight);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            mclk_q    <= 1'b0;
            sclk_q    <= 1'b0;
            lrck_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            mclk_q    <= mclk_d;
            sclk_q    <= sclk_d;
            lrck_q    <= lrck_d;
        end
    end

    assign mclk = mclk_q;
    assign sclk = sclk_q;
    assign lrck = lrck_q;

endmodule

// File: rtl/i2s_receiver.sv
// Master-mode I2S receiver for the line-in ADC: deserialises stereo frames into a
// one-entry valid/ready buffer. I2S_RECEIVER_MONO_MIX_EN adds a registered mono mix.
module i2s_receiver
    import synth_audio_pkg::*;
#(
    parameter int unsigned WIDTH        = 16,
    parameter int unsigned CLK_PER_SCLK = AUDIO_CLK_PER_SCLK,
    parameter int unsigned SLOTS        = AUDIO_SLOTS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             mclk,
    output logic             lrck,
    output logic             sclk,
    input  logic             sdout,
    output logic [WIDTH-1:0] left,
    output logic [WIDTH-1:0] right,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    input  logic             clr_ovf
`ifdef I2S_RECEIVER_MONO_MIX_EN
    ,
    output logic [WIDTH-1:0] mono
`endif
);

    logic cap_bit;
    logic left_end;
    logic frame_end;

    i2s_clkgen #(
        .WIDTH       (WIDTH),
        .CLK_PER_SCLK(CLK_PER_SCLK),
        .SLOTS       (SLOTS)
    ) u_clkgen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mclk     (mclk),
        .sclk     (sclk),
        .lrck     (lrck),
        .cap_bit  (cap_bit),
        .left_end (left_end),
        .frame_end(frame_end)
    );

    logic [1:0]       sync_q;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] shift_next;
    logic [WIDTH-1:0] left_q, left_d;
    logic [WIDTH-1:0] right_q, right_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             load;

    // Includes the bit being captured this clk, so word ends need no extra cycle.
    assign shift_next = {shift_q[WIDTH-2:0], sync_q[1]};
    assign load       = frame_end;

    always_comb begin
        shift_d  = shift_q;
        shadow_d = shadow_q;
        if (!en) begin
            shift_d  = '0;
            shadow_d = '0;
        end else begin
            if (cap_bit) begin
                shift_d = shift_next;
            end
            if (left_end) begin
                shadow_d = shift_next;
            end
        end
    end

    always_comb begin
        left_d  = left_q;
        right_d = right_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (load) begin
            left_d  = shadow_q;
            right_d = shift_next;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        // Latest frame wins; the set takes priority over a same-cycle clear.
        if (load && valid_q && !out_ready) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            shift_q  <= '0;
            shadow_q <= '0;
            left_q   <= '0;
            right_q  <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], sdout};
            shift_q  <= shift_d;
            shadow_q <= shadow_d;
            left_q   <= left_d;
            right_q  <= right_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
        end
    end

    assign left      = left_q;
    assign right     = right_q;
    assign out_valid = valid_q;
    assign overflow  = ovf_q;

`ifdef I2S_RECEIVER_MONO_MIX_EN
    logic [WIDTH:0]   mix_sum;
    logic [WIDTH-1:0] mono_q, mono_d;

    // Dropping the sum LSB is an arithmetic shift, i.e. rounds toward -inf.
    assign mix_sum = {shadow_q[WIDTH-1], shadow_q} + {shift_next[WIDTH-1], shift_next};

    always_comb begin
        mono_d = mono_q;
        if (load) begin
            mono_d = mix_sum[WIDTH:1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mono_q <= '0;
        end else begin
            mono_q <= mono_d;
        end
    end

    assign mono = mono_q;
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: an ADC model shifts frames out on falling SCLK
// and each step checks the buffered samples, handshake, overflow and clock outputs.
module tb_i2s_receiver;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        en        = 1'b0;
    logic        sdout     = 1'b0;
    logic        out_ready = 1'b0;
    logic        clr_ovf   = 1'b0;
    logic        mclk, lrck, sclk, out_valid, overflow;
    logic [15:0] left, right;
`ifdef I2S_RECEIVER_MONO_MIX_EN
    logic [15:0] mono;
`endif

    logic [15:0] tx_l    = 16'h0;
    logic [15:0] tx_r    = 16'h0;
    logic        tx_fill = 1'b0;
    int          idx     = 0;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    i2s_receiver dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mclk     (mclk),
        .lrck     (lrck),
        .sclk     (sclk),
        .sdout    (sdout),
        .left     (left),
        .right    (right),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
`ifdef I2S_RECEIVER_MONO_MIX_EN
        ,
        .mono     (mono)
`endif
    );

    // Bit k of the 64-slot frame: slot 1 = MSB .. slot 16 = LSB, rest = fill.
    function automatic logic tx_bit(input int i);
        int          b;
        int          s;
        logic [15:0] w;
        b = i % 64;
        s = b % 32;
        w = (b < 32) ? tx_l : tx_r;
        if (s >= 1 && s <= 16) return w[16-s];
        return tx_fill;
    endfunction

    // ADC model: the k-th falling SCLK after enable starts bit k.
    always @(negedge sclk or negedge en) begin
        if (!en) idx = 0;
        else     idx = idx + 1;
        sdout = tx_bit(idx);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic pick(input int sel);
        if (sel == 0) return mclk;
        if (sel == 1) return sclk;
        return lrck;
    endfunction

    // Clk cycles between two rising edges of the selected clock; 0 on timeout.
    task automatic measure(input int sel, output int p);
        logic prev, cur;
        int   t0;
        p    = 0;
        t0   = -1;
        prev = pick(sel);
        for (int i = 1; i <= 4000; i++) begin
            @(negedge clk);
            cur = pick(sel);
            if (cur && !prev) begin
                if (t0 < 0) begin
                    t0 = i;
                end else begin
                    p = i - t0;
                    break;
                end
            end
            prev = cur;
        end
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (out_valid) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          p, n, cnt, first;
        logic        acc;
        logic [15:0] cap_l, cap_r;
`ifdef I2S_RECEIVER_MONO_MIX_EN
        logic [15:0] cap_m;
        cap_m = 16'h0;
`endif
        cap_l = 16'h0;
        cap_r = 16'h0;

        // Reset held with en=1: nothing toggles, outputs at zero.
        en = 1'b1;
        #1 rst_n = 1'b0;
        acc = 1'b0;
        repeat (12) begin
            @(negedge clk);
            acc |= mclk | sclk | lrck;
        end
        check("rst_no_toggle", 32'(acc), 32'h0);
        check("rst_left", 32'(left), 32'h0);
        check("rst_right", 32'(right), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);

        rst_n = 1'b1;
        measure(0, p);
        check("mclk_period", 32'(p), 32'd4);
        measure(1, p);
        check("sclk_period", 32'(p), 32'd16);
        measure(2, p);
        check("lrck_period", 32'(p), 32'd1024);

        // Drain whatever the free run produced and clear its overflow.
        en        = 1'b0;
        out_ready = 1'b1;
        clr_ovf   = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        @(negedge clk);
        check("drain_valid", 32'(out_valid), 32'h0);
        check("drain_overflow", 32'(overflow), 32'h0);

        // Single frame: valid first visible 778 clks after en rises.
        tx_l    = 16'h8001;
        tx_r    = 16'h7FFE;
        tx_fill = 1'b0;
        en      = 1'b1;
        acc     = 1'b0;
        repeat (777) begin
            @(negedge clk);
            acc |= out_valid;
        end
        check("sf_early_valid", 32'(acc), 32'h0);
        @(negedge clk);
        check("sf_valid", 32'(out_valid), 32'h1);
        check("sf_left", 32'(left), 32'h8001);
        check("sf_right", 32'(right), 32'h7FFE);
        check("sf_overflow", 32'(overflow), 32'h0);
`ifdef I2S_RECEIVER_MONO_MIX_EN
        check("sf_mono", 32'(mono), 32'hFFFF);
`endif
        @(negedge clk);
        check("sf_valid_drop", 32'(out_valid), 32'h0);

        // Slot masking: ones in slot 0 and padding slots must not leak in.
        tx_fill = 1'b1;
        wait_valid(2000, n);
        check("mask_latency", 32'(n), 32'd1023);
        check("mask_left", 32'(left), 32'h8001);
        check("mask_right", 32'(right), 32'h7FFE);
        @(negedge clk);
        check("mask_valid_drop", 32'(out_valid), 32'h0);

        // Backpressure: frame B overwrites unconsumed A and flags overflow.
        tx_fill   = 1'b0;
        out_ready = 1'b0;
        tx_l      = 16'h1234;
        tx_r      = 16'h5678;
        wait_valid(2000, n);
        check("bp_a_latency", 32'(n), 32'd1023);
        check("bp_a_left", 32'(left), 32'h1234);
        check("bp_a_right", 32'(right), 32'h5678);
        check("bp_a_overflow", 32'(overflow), 32'h0);
        tx_l = 16'h9ABC;
        tx_r = 16'hDEF0;
        repeat (1024) @(negedge clk);
        check("bp_b_overflow", 32'(overflow), 32'h1);
        check("bp_b_valid", 32'(out_valid), 32'h1);
        check("bp_b_left", 32'(left), 32'h9ABC);
        check("bp_b_right", 32'(right), 32'hDEF0);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("bp_clr_overflow", 32'(overflow), 32'h0);
        check("bp_clr_valid_held", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_drop", 32'(out_valid), 32'h0);

        // Enable abort at bit_cnt 20, then a clean frame after re-enable.
        en = 1'b0;
        repeat (2) @(negedge clk);
        tx_l = 16'h1111;
        tx_r = 16'h2222;
        en   = 1'b1;
        repeat (325) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("abort_clocks_low", 32'({mclk, sclk, lrck}), 32'h0);
        acc = 1'b0;
        repeat (49) begin
            @(negedge clk);
            acc |= out_valid | sclk | lrck | mclk;
        end
        check("abort_quiet", 32'(acc), 32'h0);

        tx_l  = 16'h0F0F;
        tx_r  = 16'hF0F0;
        en    = 1'b1;
        cnt   = 0;
        first = 0;
        for (int i = 1; i <= 800; i++) begin
            @(negedge clk);
            if (out_valid) begin
                cnt++;
                if (first == 0) begin
                    first = i;
                    cap_l = left;
                    cap_r = right;
`ifdef I2S_RECEIVER_MONO_MIX_EN
                    cap_m = mono;
`endif
                end
            end
        end
        check("reen_count", 32'(cnt), 32'd1);
        check("reen_latency", 32'(first), 32'd778);
        check("reen_left", 32'(cap_l), 32'h0F0F);
        check("reen_right", 32'(cap_r), 32'hF0F0);
`ifdef I2S_RECEIVER_MONO_MIX_EN
        check("reen_mono", 32'(cap_m), 32'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
